mem_wb_skid: RTL
================

// Module: mem_wb_skid
// PURPOSE
//  Parametrised MEM->WB pipeline stage. Next generation of the plain MEM/WB latch.
//  Elastic valid/ready boundary with a 2-entry skid buffer, a synchronous flush and an optional HI/LO write channel.
//  WB (regfile + HI/LO) can stall without a combinational ready path back into MEM.
//  Sits between the mem stage and regfile/hilo_reg; payload is forwarded unchanged.
// PARAMETERS
//  DATA_W     32  width of GPR write data and of each of HI, LO
//  ADDR_W     5   GPR destination address width
//  HILO_EN    1   1: HI/LO channel present; 0: wb_whilo tied 0, wb_hi/wb_lo tied 0
//  ZERO_GUARD 1   1: a capture with mem_wd==0 forces the stored wreg to 0 ($zero is never written)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  flush      in   1       synchronous pipeline flush (exception/eret)
//  mem_valid  in   1       MEM presents an instruction result
//  mem_ready  out  1       stage can accept this cycle
//  mem_wd     in   ADDR_W  GPR destination
//  mem_wreg   in   1       GPR write enable
//  mem_wdata  in   DATA_W  GPR write data
//  mem_whilo  in   1       HI/LO write enable
//  mem_hi     in   DATA_W  HI write data
//  mem_lo     in   DATA_W  LO write data
//  wb_valid   out  1       WB payload valid
//  wb_ready   in   1       WB consumes payload this cycle
//  wb_wd      out  ADDR_W  registered GPR destination
//  wb_wreg    out  1       registered GPR write enable
//  wb_wdata   out  DATA_W  registered GPR write data
//  wb_whilo   out  1       registered HI/LO write enable
//  wb_hi      out  DATA_W  registered HI data
//  wb_lo      out  DATA_W  registered LO data
// BEHAVIOUR
//  - Reset (rst==0, async): state=EMPTY; wb_valid=0, wb_wd=0, wb_wreg=0, wb_wdata=0, wb_whilo=0,
//    wb_hi=0, wb_lo=0, skid entry cleared. While rst==0, mem_ready=0. From the first edge after
//    release, mem_ready=1.
//  - in_fire = mem_valid & mem_ready. out_fire = wb_valid & wb_ready.
//  - Entries: OUT (drives wb_*) and SKID (hidden).
//  - State encoding: EMPTY (no entries), ONE (OUT full), FULL (OUT+SKID full).
//  - wb_valid = (state != EMPTY). mem_ready = (state != FULL).
//  - mem_ready is decoded from the state register only; no combinational path from wb_ready.
//  - EMPTY: in_fire -> OUT<=in, ONE.
//  - ONE:
//      in_fire & out_fire   -> OUT<=in, stay ONE
//      in_fire & !out_fire  -> SKID<=in, FULL
//      !in_fire & out_fire  -> OUT<=0, EMPTY
//      otherwise            -> hold
//  - FULL: no in_fire possible.
//      out_fire  -> OUT<=SKID, SKID<=0, ONE
//      otherwise -> hold
//  - Latency: 1 cycle when WB is not stalled (in_fire at edge N -> wb_valid from N+1).
//  - Throughput: 1 instruction/cycle with wb_ready=1.
//  - Order is strictly preserved. No payload is duplicated or dropped.
//  - Flush (sync):
//      OUT and SKID zeroed, state=EMPTY.
//      Any same-cycle in_fire is discarded.
//      An out_fire in the same cycle still counts as consumed by WB.
//      Flush has priority over all transitions.
//  - While wb_valid==0, all wb_* payload outputs read 0 (NOP semantics, WriteDisable).
//  - Payload is captured exactly as presented, except:
//      ZERO_GUARD=1 & mem_wd==0 -> stored wreg=0
//      HILO_EN=0                -> HI/LO fields are never stored
//  - Reset mid-operation: both entries are lost, outputs go to reset values immediately (async).
//  - All widths are pass-through; no arithmetic.
// TESTING
//  1. Stream, wb_ready=1: wd=3/wreg=1/wdata=0x1234_5678 at N
//     -> wb_* equal at N+1, wb_valid=1; 8 back-to-back in 8 cycles.
//  2. Stall: send A (wdata=0xA), B (0xB) with wb_ready=0
//     -> mem_ready=0 after B; raise wb_ready: A then B in order, C accepted once FULL clears.
//  3. Flush in FULL: A,B held, flush=1 with mem_valid=1 (C)
//     -> next cycle wb_valid=0, all wb_*=0, C not seen at WB.
//  4. $zero guard: mem_wd=0, mem_wreg=1, wdata=0xFFFF_FFFF
//     -> wb_wreg=0 (ZERO_GUARD=1); wb_wreg=1 with ZERO_GUARD=0.
//  5. HI/LO: mem_whilo=1, hi=0xDEAD_BEEF, lo=0x0000_0001
//     -> registered next cycle with HILO_EN=1; all 0 with HILO_EN=0.
//  6. Async reset asserted mid-FULL, between edges
//     -> wb_valid=0, wb_*=0 without a clock edge; mem_ready=1 one edge after release.

Source files
------------

// File: rtl/mem_wb_skid_if.sv
// Purpose: one valid/ready hop carrying a MEM->WB result (GPR write + optional HI/LO write).
// Latency: none, this is a bundle of wires with no state.
// Backpressure: the consumer drives ready; the producer holds valid and payload until ready.
// Ports: valid/ready handshake; wd/wreg/wdata GPR write; whilo/hi/lo HI/LO write.
interface mem_wb_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] wd;
  logic              wreg;
  logic [DATA_W-1:0] wdata;
  logic              whilo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Producer side: drives the payload, observes ready.
  modport master (
    output valid, wd, wreg, wdata, whilo, hi, lo,
    input  ready
  );

  // Consumer side: observes the payload, drives ready.
  modport slave (
    input  valid, wd, wreg, wdata, whilo, hi, lo,
    output ready
  );
endinterface

// File: rtl/mem_wb_skid.sv
// Purpose: elastic MEM->WB pipeline register with a 2-entry skid buffer and sync flush.
// Latency: 1 cycle from MEM handshake to wb valid when WB is not stalled; 1 instr/cycle.
// Backpressure: mem ready is decoded from registered state only, never from wb ready.
// Ports: clk, rst (async active-low), flush (sync); mem = slave side from MEM stage,
//        wb = master side towards regfile/hilo_reg.
module mem_wb_skid #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int HILO_EN    = 1,
  parameter int ZERO_GUARD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  mem_wb_skid_if.slave  mem,
  mem_wb_skid_if.master wb
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } pay_t;

  // EMPTY: nothing held. ONE: OUT holds the head. FULL: OUT holds head, SKID holds next.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  pay_t   out_q;
  pay_t   skid_q;
  pay_t   in_pay;
  logic   live_q;     // low in reset and until the first edge after release
  logic   rdy;
  logic   zero_dst;
  logic   in_fire;
  logic   out_fire;

  assign rdy      = live_q && (state != FULL);
  assign mem.ready = rdy;
  assign wb.valid  = (state != EMPTY);
  assign in_fire  = mem.valid && rdy;
  assign out_fire = (state != EMPTY) && wb.ready;

  // $zero is hard-wired; suppress its write enable at capture so WB never sees it.
  assign zero_dst = (ZERO_GUARD != 0) && (mem.wd == '0);

  always_comb begin
    in_pay       = '0;
    in_pay.wd    = mem.wd;
    in_pay.wreg  = mem.wreg && !zero_dst;
    in_pay.wdata = mem.wdata;
    if (HILO_EN != 0) begin
      in_pay.whilo = mem.whilo;
      in_pay.hi    = mem.hi;
      in_pay.lo    = mem.lo;
    end
  end

  // OUT is kept at zero whenever the stage is empty, so wb_* read as a NOP
  // without any output masking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (flush) begin
        // A same-cycle in_fire is dropped; a same-cycle out_fire was consumed by WB.
        state  <= EMPTY;
        out_q  <= '0;
        skid_q <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              out_q <= in_pay;
              state <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              out_q <= in_pay;
            end else if (in_fire) begin
              skid_q <= in_pay;
              state  <= FULL;
            end else if (out_fire) begin
              out_q <= '0;
              state <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              out_q  <= skid_q;
              skid_q <= '0;
              state  <= ONE;
            end
          end
          default: begin
            out_q  <= '0;
            skid_q <= '0;
            state  <= EMPTY;
          end
        endcase
      end
    end
  end

  assign wb.wd    = out_q.wd;
  assign wb.wreg  = out_q.wreg;
  assign wb.wdata = out_q.wdata;
  assign wb.whilo = out_q.whilo;
  assign wb.hi    = out_q.hi;
  assign wb.lo    = out_q.lo;

endmodule
